// File: rtl/rv32im_cpu_if.sv
// rv32im_cpu_if: instruction input and data-memory port of the rv32im_cpu core.
interface rv32im_cpu_if;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic [31:0] READ_DATA;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [31:0] MEM_WRITE_DATA;
  logic [31:0] MEM_ADDRESS;
  modport master (
    input  PC, INSTRUCTION, READ_DATA,
    output MEM_READ, MEM_WRITE, MEM_WRITE_DATA, MEM_ADDRESS
  );
  modport slave (
    output PC, INSTRUCTION, READ_DATA,
    input  MEM_READ, MEM_WRITE, MEM_WRITE_DATA, MEM_ADDRESS
  );
endinterface

// File: rtl/rv32im_cpu.sv
// rv32im_cpu: 3-stage RV32I core (ID/EX, MEM, WB); define RV32M_EN to add single-cycle RV32M multiply/divide.
module rv32im_cpu (
  input logic          CLK,
  input logic          RESET,
  rv32im_cpu_if.master bus
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d, res_q, res_d, wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d, mr_q, mr_d, mw_q, mw_d;
  logic [31:0] rf_q [32];
  logic [6:0]  opc, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] wb_data, a, b, rs2_v, imm_i, imm_s, imm_u, alu, sra, m_res;
  logic signed [31:0] sa, sb;
  logic        is_op, is_opi, is_lui, is_auipc, is_lw, is_sw, op_ok, opi_ok;
  assign {f7, rs2, rs1, f3, rd, opc} = instr_q;
  assign wb_data = mr_q ? bus.READ_DATA : res_q;
  assign bus.MEM_READ = mr_q;
  assign bus.MEM_WRITE = mw_q;
  assign bus.MEM_ADDRESS = res_q;
  assign bus.MEM_WRITE_DATA = wdata_q;
`ifdef RV32M_EN
  localparam logic M_EN = 1'b1;
  logic [63:0] prod;
  logic signed [31:0] dv, sq, sr;
  logic [31:0] du;
  logic        div0, ovf;
  always_comb begin
    prod = {{32{a[31] & (f3 == 3'b001 || f3 == 3'b010)}}, a} * {{32{b[31] & (f3 == 3'b001)}}, b};
    div0 = b == '0;
    ovf = a == 32'h8000_0000 && b == '1;
    // divisors are steered away from 0 and the overflow case so the dividers never see them
    dv = (div0 || ovf) ? 32'sd1 : sb;
    du = div0 ? 32'd1 : b;
    sq = sa / dv;
    sr = sa % dv;
    case (f3)
      3'b000:  m_res = prod[31:0];
      3'b001,
      3'b010,
      3'b011:  m_res = prod[63:32];
      3'b100:  m_res = div0 ? '1 : ovf ? a : sq;
      3'b101:  m_res = div0 ? '1 : a / du;
      3'b110:  m_res = div0 ? a : ovf ? '0 : sr;
      default: m_res = div0 ? a : a % du;
    endcase
  end
`else
  localparam logic M_EN = 1'b0;
  assign m_res = '0;
`endif
  always_comb begin
    imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    imm_s = {{20{instr_q[31]}}, f7, rd};
    imm_u = {instr_q[31:12], 12'b0};
    // single bypass from EX/MEM; anything older is already in the register file
    a = (we_q && rd_q == rs1) ? wb_data : rf_q[rs1];
    rs2_v = (we_q && rd_q == rs2) ? wb_data : rf_q[rs2];
    is_op = opc == 7'b0110011;
    is_opi = opc == 7'b0010011;
    is_lui = opc == 7'b0110111;
    is_auipc = opc == 7'b0010111;
    is_lw = opc == 7'b0000011 && f3 == 3'b010;
    is_sw = opc == 7'b0100011 && f3 == 3'b010;
    b = is_op ? rs2_v : imm_i;
    sa = a;
    sb = b;
    sra = sa >>> b[4:0];
    case (f3)
      3'b000:  alu = (is_op && f7[5]) ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, sa < sb};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = f7[5] ? sra : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
    op_ok = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) || (M_EN && f7 == 7'b0000001);
    opi_ok = f3 == 3'b001 ? f7 == 7'b0 : f3 == 3'b101 ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
    we_d = ((is_op && op_ok) || (is_opi && opi_ok) || is_lui || is_auipc || is_lw) && rd != '0;
    mr_d = is_lw;
    mw_d = is_sw;
    rd_d = rd;
    res_d = is_lui ? imm_u :
            is_auipc ? pc_q + imm_u :
            (is_lw || is_sw) ? a + (is_sw ? imm_s : imm_i) :
            (is_op && f7 == 7'b0000001) ? m_res : alu;
    wdata_d = rs2_v;
    instr_d = bus.INSTRUCTION;
    pc_d = bus.PC;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_q <= '0;
      pc_q <= '0;
      res_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
      mr_q <= 1'b0;
      mw_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q <= pc_d;
      res_q <= res_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      we_q <= we_d;
      mr_q <= mr_d;
      mw_q <= mw_d;
      if (we_q) rf_q[rd_q] <= wb_data;
    end
  end
endmodule

// File: tb/tb_rv32im_cpu.sv
// tb_rv32im_cpu: table-driven scoreboard bench; each vector's MEM-stage outputs are checked two cycles after issue.
module tb_rv32im_cpu;
  typedef struct {
    int          id;
    logic [31:0] instr, pc, rdata;
    logic        mr, mw, ca, cw;
    logic [31:0] addr, wd;
  } vec_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OPI = 7'b0010011;
`ifdef RV32M_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];
  rv32im_cpu_if bus ();
  rv32im_cpu dut (.CLK(clk), .RESET(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] r(input logic [6:0] f7, input logic [4:0] s2, s1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] ii(input logic [11:0] imm, input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction
  function automatic logic [31:0] st(input logic [11:0] imm, input logic [4:0] s2, s1, input logic [2:0] f3);
    return {imm[11:5], s2, s1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic vec_t mk(input logic [31:0] instr, input logic mr, mw, ca, cw, input logic [31:0] addr, wd, rdata);
    vec_t v;
    v.id = 0; v.instr = instr; v.pc = '0; v.rdata = rdata;
    v.mr = mr; v.mw = mw; v.ca = ca; v.cw = cw; v.addr = addr; v.wd = wd;
    return v;
  endfunction
  function automatic vec_t av(input logic [31:0] instr, res);
    return mk(instr, 1'b0, 1'b0, 1'b1, 1'b0, res, '0, '0);
  endfunction
  function automatic vec_t nv(input logic [31:0] instr);
    return mk(instr, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endfunction
  function automatic vec_t sv(input logic [11:0] imm, input logic [4:0] s2, s1, input logic [31:0] addr, wd);
    return mk(st(imm, s2, s1, 3'b010), 1'b0, 1'b1, 1'b1, 1'b1, addr, wd, '0);
  endfunction
  function automatic vec_t mv(input logic [31:0] instr, res);
    return M ? av(instr, res) : nv(instr);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " mem_read"}, {31'b0, bus.MEM_READ}, 32'd0);
    chk({nm, " mem_write"}, {31'b0, bus.MEM_WRITE}, 32'd0);
    chk({nm, " mem_address"}, bus.MEM_ADDRESS, 32'd0);
    chk({nm, " mem_write_data"}, bus.MEM_WRITE_DATA, 32'd0);
  endtask
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      chk($sformatf("v%0d mem_read", e.id), {31'b0, bus.MEM_READ}, {31'b0, e.mr});
      chk($sformatf("v%0d mem_write", e.id), {31'b0, bus.MEM_WRITE}, {31'b0, e.mw});
      if (e.ca) chk($sformatf("v%0d mem_address", e.id), bus.MEM_ADDRESS, e.addr);
      if (e.cw) chk($sformatf("v%0d mem_write_data", e.id), bus.MEM_WRITE_DATA, e.wd);
      bus.READ_DATA = e.rdata;
    end
    bus.INSTRUCTION = v.instr;
    bus.PC = v.pc;
    sb.push_back(v);
  endtask
  initial begin
    vec_t v;
    bus.PC = '0;
    bus.READ_DATA = '0;
    bus.INSTRUCTION = ii(12'd99, 5'd0, 3'b000, 5'd1, OPI);
    tbl.push_back(av(ii(12'd5, 5'd0, 3'b000, 5'd1, OPI), 32'd5));
    tbl.push_back(av(ii(12'd7, 5'd0, 3'b000, 5'd2, OPI), 32'd7));
    tbl.push_back(av(r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd12));
    tbl.push_back(sv(12'd0, 5'd3, 5'd0, 32'd0, 32'd12));
    tbl.push_back(av(ii(12'h030, 5'd0, 3'b000, 5'd4, OPI), 32'h30));
    tbl.push_back(av(r(7'h00, 5'd4, 5'd3, 3'b110, 5'd5), 32'h3C));
    tbl.push_back(av(r(7'h00, 5'd3, 5'd5, 3'b111, 5'd7), 32'h0C));
    tbl.push_back(av(r(7'h00, 5'd5, 5'd7, 3'b100, 5'd9), 32'h30));
    tbl.push_back(sv(12'd8, 5'd9, 5'd0, 32'd8, 32'h30));
    tbl.push_back(mk(ii(12'd4, 5'd0, 3'b010, 5'd6, 7'b0000011), 1'b1, 1'b0, 1'b1, 1'b0, 32'd4, '0, 32'hDEAD_BEEF));
    tbl.push_back(av(ii(12'd1, 5'd6, 3'b000, 5'd6, OPI), 32'hDEAD_BEF0));
    tbl.push_back(sv(12'd0, 5'd6, 5'd0, 32'd0, 32'hDEAD_BEF0));
    tbl.push_back(av(ii(12'd9, 5'd0, 3'b000, 5'd0, OPI), 32'd9));
    tbl.push_back(sv(12'd0, 5'd0, 5'd0, 32'd0, 32'd0));
    tbl.push_back(av(ii(12'd1, 5'd0, 3'b000, 5'd11, OPI), 32'd1));
    tbl.push_back(av(r(7'h20, 5'd11, 5'd0, 3'b000, 5'd10), 32'hFFFF_FFFF));
    tbl.push_back(av({20'h80000, 5'd12, 7'b0110111}, 32'h8000_0000));
    tbl.push_back(av(ii({7'h20, 5'd31}, 5'd12, 3'b101, 5'd13, OPI), 32'hFFFF_FFFF));
    tbl.push_back(av(ii(12'd31, 5'd12, 3'b101, 5'd14, OPI), 32'd1));
    tbl.push_back(av(r(7'h00, 5'd11, 5'd12, 3'b010, 5'd15), 32'd1));
    tbl.push_back(av(r(7'h00, 5'd11, 5'd12, 3'b011, 5'd16), 32'd0));
    tbl.push_back(av(ii(12'd0, 5'd13, 3'b010, 5'd17, OPI), 32'd1));
    tbl.push_back(av(ii(12'hFFF, 5'd11, 3'b011, 5'd18, OPI), 32'd1));
    tbl.push_back(av(r(7'h00, 5'd2, 5'd11, 3'b001, 5'd19), 32'h80));
    tbl.push_back(av(r(7'h20, 5'd11, 5'd12, 3'b101, 5'd20), 32'hC000_0000));
    tbl.push_back(av(ii(12'hFFF, 5'd1, 3'b100, 5'd21, OPI), 32'hFFFF_FFFA));
    tbl.push_back(av(ii(12'h100, 5'd1, 3'b110, 5'd22, OPI), 32'h105));
    tbl.push_back(av(ii(12'h07F, 5'd13, 3'b111, 5'd23, OPI), 32'h7F));
    tbl.push_back(av(ii(12'd4, 5'd11, 3'b001, 5'd24, OPI), 32'h10));
    v = av({20'h12345, 5'd25, 7'b0010111}, 32'h1234_5100);
    v.pc = 32'h100;
    tbl.push_back(v);
    tbl.push_back(av(r(7'h00, 5'd11, 5'd13, 3'b000, 5'd26), 32'd0));
    tbl.push_back(nv(ii(12'd5, 5'd1, 3'b000, 5'd27, 7'b1111111)));
    tbl.push_back(sv(12'd0, 5'd27, 5'd0, 32'd0, 32'd0));
    tbl.push_back(nv(r(7'h20, 5'd1, 5'd1, 3'b001, 5'd27)));
    tbl.push_back(sv(12'd0, 5'd27, 5'd0, 32'd0, 32'd0));
    tbl.push_back(mk(ii(12'd0, 5'd0, 3'b000, 5'd28, 7'b0000011), 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h1234_5678));
    tbl.push_back(nv(st(12'd0, 5'd1, 5'd0, 3'b000)));
    tbl.push_back(sv(12'd0, 5'd28, 5'd0, 32'd0, 32'd0));
    tbl.push_back(sv(12'hFFC, 5'd1, 5'd2, 32'd3, 32'd5));
    tbl.push_back(av(ii(12'd6, 5'd0, 3'b000, 5'd29, OPI), 32'd6));
    tbl.push_back(mv(r(7'h01, 5'd2, 5'd29, 3'b000, 5'd31), 32'd42));
    tbl.push_back(sv(12'd0, 5'd31, 5'd0, 32'd0, M ? 32'd42 : 32'd0));
    tbl.push_back(mv(r(7'h01, 5'd0, 5'd1, 3'b100, 5'd31), 32'hFFFF_FFFF));
    tbl.push_back(sv(12'd0, 5'd31, 5'd0, 32'd0, M ? 32'hFFFF_FFFF : 32'd0));
    tbl.push_back(mv(r(7'h01, 5'd0, 5'd1, 3'b110, 5'd31), 32'd5));
    tbl.push_back(mv(r(7'h01, 5'd13, 5'd12, 3'b110, 5'd31), 32'd0));
    tbl.push_back(mv(r(7'h01, 5'd13, 5'd12, 3'b100, 5'd31), 32'h8000_0000));
    tbl.push_back(mv(r(7'h01, 5'd12, 5'd12, 3'b001, 5'd31), 32'h4000_0000));
    tbl.push_back(mv(r(7'h01, 5'd13, 5'd13, 3'b011, 5'd31), 32'hFFFF_FFFE));
    tbl.push_back(mv(r(7'h01, 5'd13, 5'd13, 3'b010, 5'd31), 32'hFFFF_FFFF));
    tbl.push_back(mv(r(7'h01, 5'd2, 5'd13, 3'b101, 5'd31), 32'h2492_4924));
    tbl.push_back(mv(r(7'h01, 5'd2, 5'd13, 3'b111, 5'd31), 32'd3));
    tbl.push_back(mv(r(7'h01, 5'd1, 5'd21, 3'b100, 5'd31), 32'hFFFF_FFFF));
    tbl.push_back(mv(r(7'h01, 5'd1, 5'd21, 3'b110, 5'd31), 32'hFFFF_FFFF));
    tbl.push_back(nv(NOP));
    tbl.push_back(nv(NOP));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.INSTRUCTION = NOP;
    chk_zero("reset");
    for (int i = 0; i < tbl.size(); i++) begin
      tbl[i].id = i;
      step(tbl[i]);
    end
    step(av(ii(12'd5, 5'd0, 3'b000, 5'd1, OPI), 32'd5));
    @(negedge clk);
    rst = 1'b1;
    bus.INSTRUCTION = ii(12'd3, 5'd0, 3'b000, 5'd2, OPI);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.INSTRUCTION = NOP;
    chk_zero("mid reset");
    v = sv(12'd0, 5'd1, 5'd0, 32'd0, 32'd0);   v.id = 100; step(v);
    v = sv(12'd4, 5'd2, 5'd0, 32'd4, 32'd0);   v.id = 101; step(v);
    v = sv(12'd8, 5'd3, 5'd0, 32'd8, 32'd0);   v.id = 102; step(v);
    v = av(ii(12'd3, 5'd0, 3'b000, 5'd1, OPI), 32'd3); v.id = 103; step(v);
    v = sv(12'd12, 5'd1, 5'd0, 32'd12, 32'd3); v.id = 104; step(v);
    repeat (2) step(nv(NOP));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
